// File: rtl/bc_operand_injector_pkg.sv
// Types and helpers shared by the broadcast operand chain.
// Element unpacking and replication of 64-bit VRF words.
package bc_operand_injector_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } bc_state_e;

  function automatic logic [3:0] bc_elems_per_word(vew_e vew);
    logic [3:0] n;
    case (vew)
      EW8:     n = 4'd8;
      EW16:    n = 4'd4;
      EW32:    n = 4'd2;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic elen_t bc_replicate(
    elen_t      word,
    logic [2:0] idx,
    vew_e       vew
  );
    elen_t res;
    case (vew)
      EW8:     res = {8{word[{idx, 3'b000} +: 8]}};
      EW16:    res = {4{word[{idx[1:0], 4'b0000} +: 16]}};
      EW32:    res = {2{word[{idx[0], 5'b00000} +: 32]}};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bc_operand_injector.sv
// Head of the matmul broadcast chain: unpacks VRF words into
// SEW elements, replicates each across 64 bits, feeds lane 0.
module bc_operand_injector
  import bc_operand_injector_pkg::*;
#(
  parameter int unsigned NrElemsWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [NrElemsWidth-1:0] cmd_num_elems_i,
  input  logic [1:0]              cmd_vew_i,
  input  logic                    operand_valid_i,
  output logic                    operand_ready_o,
  input  logic [63:0]             operand_data_i,
  output logic                    bc_valid_o,
  input  logic                    bc_ready_i,
  output logic [63:0]             bc_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  bc_state_e               state_q, state_d;
  vew_e                    vew_q, vew_d;
  logic [NrElemsWidth-1:0] elems_left_q, elems_left_d;
  elen_t                   word_q, word_d;
  logic                    word_valid_q, word_valid_d;
  logic [2:0]              idx_q, idx_d;
  logic                    done_q, done_d;

  logic                    bc_hs;
  logic                    op_hs;
  logic                    cmd_hs;
  logic                    last_idx;
  logic                    last_elem;
  logic                    retire;
  logic [NrElemsWidth-1:0] elems_after;

  assign bc_hs = word_valid_q & bc_ready_i;

  // Saturating: the count only moves on a real element handshake
  assign elems_after = (bc_hs && elems_left_q != '0)
                     ? elems_left_q - NrElemsWidth'(1)
                     : elems_left_q;

  assign last_idx  = {1'b0, idx_q} ==
                     (bc_elems_per_word(vew_q) - 4'd1);
  assign last_elem = bc_hs && (elems_after == '0);
  assign retire    = bc_hs && (last_idx || last_elem);

  assign operand_ready_o = (state_q == STREAM)
                         && (!word_valid_q || retire)
                         && (elems_after != '0);

  assign op_hs       = operand_valid_i & operand_ready_o;
  assign cmd_ready_o = (state_q == IDLE);
  assign cmd_hs      = cmd_valid_i & cmd_ready_o & ~flush_i;

  assign bc_valid_o = word_valid_q;
  assign bc_data_o  = bc_replicate(word_q, idx_q, vew_q);
  assign busy_o     = (state_q == STREAM);
  assign done_o     = done_q;

  always_comb begin
    state_d      = state_q;
    vew_d        = vew_q;
    elems_left_d = elems_left_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    unique case (1'b1)
      flush_i: begin
        state_d      = IDLE;
        word_valid_d = 1'b0;
        elems_left_d = '0;
        idx_d        = '0;
      end
      cmd_hs: begin
        vew_d        = vew_e'(cmd_vew_i);
        elems_left_d = cmd_num_elems_i;
        idx_d        = '0;
        word_valid_d = 1'b0;
        if (cmd_num_elems_i != '0) begin
          state_d = STREAM;
        end else begin
          done_d = 1'b1;
        end
      end
      (!flush_i && state_q == STREAM): begin
        elems_left_d = elems_after;
        if (bc_hs) begin
          idx_d = idx_q + 3'd1;
        end
        if (retire) begin
          word_valid_d = 1'b0;
          idx_d        = '0;
        end
        // Refill in the retire cycle keeps the stream gap-free
        if (op_hs) begin
          word_d       = operand_data_i;
          word_valid_d = 1'b1;
        end
        if (last_elem) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      vew_q        <= EW8;
      elems_left_q <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      idx_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vew_q        <= vew_d;
      elems_left_q <= elems_left_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_bc_operand_injector.sv
// Bench for bc_operand_injector: table vectors, random traffic
// against an element-level model, plus flush and reset sequences.
module tb_bc_operand_injector;
  import bc_operand_injector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_num = '0;
  logic [1:0]  cmd_vew = '0;
  logic        operand_valid = 1'b0;
  logic        operand_ready;
  logic [63:0] operand_data = '0;
  logic        bc_valid;
  logic        bc_ready = 1'b0;
  logic [63:0] bc_data;
  logic        busy;
  logic        done;

  int nchk = 0;
  int nerr = 0;

  logic [63:0] words[$];

  typedef struct {
    vew_e        vew;
    int          n;
    int          rdy;
    int          opv;
    bit          nob;
    bit          rnd;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w2;
  } vec_t;

  vec_t vecs[8];

  bc_operand_injector #(.NrElemsWidth(16)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .flush_i         (flush),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_num_elems_i (cmd_num),
    .cmd_vew_i       (cmd_vew),
    .operand_valid_i (operand_valid),
    .operand_ready_o (operand_ready),
    .operand_data_i  (operand_data),
    .bc_valid_o      (bc_valid),
    .bc_ready_i      (bc_ready),
    .bc_data_o       (bc_data),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Element i of the flat element stream, replicated to 64 bits
  function automatic logic [63:0] exp_elem(vew_e vew, int i);
    int          sew = 8 << int'(vew);
    int          epw = 64 / sew;
    logic [63:0] w = words[i / epw];
    logic [63:0] mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                    : ((64'd1 << sew) - 64'd1);
    logic [63:0] e = (w >> ((i % epw) * sew)) & mask;
    logic [63:0] r = '0;
    for (int k = 0; k < epw; k++) r = r | (e << (k * sew));
    return r;
  endfunction

  task automatic run_cmd(input vew_e vew, input int n, input int rdy,
                         input int opv, input bit nob);
    int          epw = 8 >> int'(vew);
    int          nw = (n + epw - 1) / epw;
    int          wi = 0;
    int          oi = 0;
    int          cyc = 0;
    int          bad_done = 0;
    int          bubbles = 0;
    bit          started = 1'b0;
    bit          fin = 1'b0;
    bit          last_hs = 1'b0;
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    logic [63:0] pdata = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_vew   = 2'(vew);
    cmd_num   = 16'(n);
    @(negedge clk);
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!fin && cyc < 400) begin
      operand_valid = (wi < nw) && ($urandom_range(99) < opv);
      operand_data  = (wi < nw) ? words[wi] : {$urandom, $urandom};
      bc_ready      = ($urandom_range(99) < rdy);
      @(negedge clk);
      if (cyc == 0 && opv == 100)
        check("op_ready_latency", 64'(operand_ready), 64'd1);
      if (cyc == 1 && opv == 100)
        check("bc_valid_latency", 64'(bc_valid), 64'd1);
      if (done !== last_hs) bad_done++;
      if (last_hs) begin
        fin = 1'b1;
        check("idle_bc_valid", 64'(bc_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
      end
      last_hs = 1'b0;
      if (pv && !pr) begin
        check("stall_valid", 64'(bc_valid), 64'd1);
        check("stall_data", bc_data, pdata);
      end
      if (started && oi < n && !bc_valid) bubbles++;
      if (operand_valid && operand_ready) wi++;
      if (bc_valid) started = 1'b1;
      if (bc_valid && bc_ready && oi < n) begin
        check($sformatf("elem%0d", oi), bc_data, exp_elem(vew, oi));
        if (oi == n - 1) last_hs = 1'b1;
        oi++;
      end
      pv    = bc_valid;
      pr    = bc_ready;
      pdata = bc_data;
      @(posedge clk); #1;
      cyc++;
    end
    operand_valid = 1'b0;
    bc_ready      = 1'b0;
    check("finished", 64'(fin), 64'd1);
    check("elem_count", 64'(oi), 64'(n));
    check("word_count", 64'(wi), 64'(nw));
    check("done_timing", 64'(bad_done), 64'd0);
    if (nob) check("no_bubble", 64'(bubbles), 64'd0);
  endtask

  task automatic fill_random(input vew_e vew, input int n);
    int epw = 8 >> int'(vew);
    words.delete();
    for (int k = 0; k < (n + epw - 1) / epw; k++)
      words.push_back({$urandom, $urandom});
  endtask

  initial begin
    vecs[0] = '{EW64, 3, 100, 100, 1'b1, 1'b0,
                64'hAAAA_AAAA_0000_0001, 64'hBBBB_BBBB_0000_0002,
                64'hCCCC_CCCC_0000_0003};
    vecs[1] = '{EW16, 6, 100, 100, 1'b1, 1'b0,
                64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555,
                64'h0};
    vecs[2] = '{EW32, 8, 60, 70, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[3] = '{EW32, 8, 100, 100, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[4] = '{EW8, 13, 50, 50, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[5] = '{EW8, 16, 100, 100, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[6] = '{EW16, 5, 70, 40, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0};
    vecs[7] = '{EW64, 1, 100, 100, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_op_ready", 64'(operand_ready), 64'd0);
    check("rst_bc_valid", 64'(bc_valid), 64'd0);
    check("rst_bc_data", bc_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rnd) begin
        fill_random(vecs[i].vew, vecs[i].n);
      end else begin
        words.delete();
        words.push_back(vecs[i].w0);
        words.push_back(vecs[i].w1);
        words.push_back(vecs[i].w2);
      end
      run_cmd(vecs[i].vew, vecs[i].n, vecs[i].rdy, vecs[i].opv,
              vecs[i].nob);
    end

    // Zero-length command
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_num   = 16'd0;
    cmd_vew   = 2'(EW32);
    operand_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_op_ready", 64'(operand_ready), 64'd0);
    check("zero_bc_valid", 64'(bc_valid), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_done_clear", 64'(done), 64'd0);
    check("zero_busy2", 64'(busy), 64'd0);
    operand_valid = 1'b0;

    // Flush after two of five EW16 elements, word still held
    words.delete();
    words.push_back(64'hDDDD_CCCC_BBBB_AAAA);
    @(posedge clk); #1;
    cmd_valid     = 1'b1;
    cmd_vew       = 2'(EW16);
    cmd_num       = 16'd5;
    operand_valid = 1'b1;
    operand_data  = words[0];
    bc_ready      = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("fl_op_ready", 64'(operand_ready), 64'd1);
    @(posedge clk); #1;
    operand_valid = 1'b0;
    @(negedge clk);
    check("fl_elem0", bc_data, exp_elem(EW16, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_elem1", bc_data, exp_elem(EW16, 1));
    @(posedge clk); #1;
    bc_ready = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    check("fl_word_held", 64'(bc_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_bc_valid", 64'(bc_valid), 64'd0);
    check("fl_done", 64'(done), 64'd0);
    check("fl_cmd_ready", 64'(cmd_ready), 64'd1);

    // Command offered together with flush must be dropped
    @(posedge clk); #1;
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_vew   = 2'(EW64);
    cmd_num   = 16'd1;
    @(posedge clk); #1;
    flush     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("fl_cmd_dropped", 64'(busy), 64'd0);
    check("fl_cmd_no_done", 64'(done), 64'd0);
    fill_random(EW64, 1);
    run_cmd(EW64, 1, 100, 100, 1'b1);

    // Asynchronous reset in the middle of a stream
    fill_random(EW8, 8);
    @(posedge clk); #1;
    cmd_valid     = 1'b1;
    cmd_vew       = 2'(EW8);
    cmd_num       = 16'd8;
    operand_valid = 1'b1;
    operand_data  = words[0];
    bc_ready      = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mrst_op_ready", 64'(operand_ready), 64'd0);
    check("mrst_bc_valid", 64'(bc_valid), 64'd0);
    check("mrst_bc_data", bc_data, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    operand_valid = 1'b0;
    bc_ready      = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    run_cmd(EW8, 8, 100, 100, 1'b1);

    // Random commands against the element model
    for (int r = 0; r < 10; r++) begin
      vew_e v = vew_e'($urandom_range(3));
      int   n = $urandom_range(1, 20);
      fill_random(v, n);
      run_cmd(v, n, $urandom_range(30, 100), $urandom_range(30, 100),
              1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bc_operand_injector.md
# bc_operand_injector

Head of the broadcast operand chain for matmul. Accepts a broadcast command plus a stream of 64-bit VRF words, unpacks each word into SEW-wide elements, and replicates every element across a full `elen_t`. It then emits one replicated element per handshake into the first lane's broadcast input. The broadcast queues in each lane forward the element down the chain and hand it to the VMFPU.

## Interface
Parameters:
- `NrElemsWidth`, default 16: width of the element counter; max elements per command is 2^NrElemsWidth−1.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  synchronous abort of the current command
- `cmd_valid_i`  in  1  command valid
- `cmd_ready_o`  out  1  command accepted (high only in IDLE)
- `cmd_num_elems_i`  in  NrElemsWidth  number of elements to broadcast
- `cmd_vew_i`  in  `vew_e` (2)  element width: EW8/16/32/64
- `operand_valid_i`  in  1  VRF word valid
- `operand_ready_o`  out  1  VRF word consumed
- `operand_data_i`  in  `elen_t` (64)  VRF word
- `bc_valid_o`  out  1  broadcast element valid to lane 0
- `bc_ready_i`  in  1  lane 0 accepts the element
- `bc_data_o`  out  `elen_t` (64)  replicated element
- `busy_o`  out  1  command in progress
- `done_o`  out  1  one-cycle pulse when a command completes

## Operation
- The FSM has two states, IDLE and STREAM.
- Registers:
  - `state_q`
  - `vew_q`
  - `elems_left_q`: elements still to send
  - `word_q`
  - `word_valid_q`
  - `idx_q`: element index inside the word, 3 bits
  - `done_q`
- IDLE: `cmd_ready_o`=1.
  - On a command handshake, latch the command fields and set `idx_q`=0 and `word_valid_q`=0.
  - If `num_elems`≠0, go to STREAM.
  - If `num_elems`=0, stay in IDLE and set `done_q`=1.
- STREAM, element output:
  - `bc_valid_o` = `word_valid_q`.
  - `bc_data_o` = element `idx_q` of `word_q`, with SEW = 8<<vew, replicated 64/SEW times.
  - Elements are taken lowest-first, element i = bits [i·SEW +: SEW].
- STREAM, per `bc` handshake: decrement `elems_left_q` and increment `idx_q`.
  - The word is retired when `idx_q` reaches 64/SEW−1, or when `elems_left_q` reaches 0.
  - Retiring clears `word_valid_q` and sets `idx_q`=0. Unsent upper elements of the final word are discarded.
- STREAM, operand input: `operand_ready_o` = (!`word_valid_q` OR word retiring this cycle) AND `elems_left` after this cycle > 0.
  - An operand handshake loads `word_q` and sets `word_valid_q`.
  - Refill in the same cycle as retire gives gap-free streaming.
- Last element handshake: go to IDLE and set `done_q`=1.
- `done_o` = `done_q`. It is cleared the following cycle.
- `busy_o` = (state == STREAM).
- `flush_i` has priority over everything:
  - Next cycle: IDLE, `word_valid_q`=0, `elems_left_q`=0, no `done_o`.
  - A command offered in the same cycle as a flush is not accepted.
- Words arriving in IDLE are not consumed (`operand_ready_o`=0).

## Timing
- Reset values: `cmd_ready_o`=1; all other outputs are 0.
  - Specifically: `operand_ready_o`, `bc_valid_o`, `bc_data_o`='0, `busy_o`, `done_o`.
- Latency:
  - Command accepted at T.
  - `operand_ready_o` rises at T+1.
  - Word accepted at T+1 gives `bc_valid_o` at T+2.
- Throughput is 1 element/cycle with `bc_ready_i` held high, including across word boundaries.
- Handshake rules:
  - Once `bc_valid_o` is asserted, `bc_data_o` stays stable until `bc_ready_i`.
  - `bc_valid_o` never depends combinationally on `bc_ready_i`.
- Combinational paths: `bc_ready_i`→`operand_ready_o` only. `bc_data_o` and `bc_valid_o` are driven from registers only.
- `done_o` is asserted exactly the cycle after the final `bc` handshake, or the cycle after a zero-length command is accepted.
- Counters never wrap. `elems_left_q` stops at 0 and is reloaded only by a command.

## Structure
- Shared additions to `matmul_pkg`:
  - function `bc_replicate(elen_t word, logic [2:0] idx, vew_e vew)` returning `elen_t`.
  - function `bc_elems_per_word(vew_e)` returning 8/4/2/1.
- `elen_t` and `vew_e` come from `ara_pkg`.
- Single module with no sub-modules. Output registering is inherent because `word_q` is the output stage.

## Test plan
- EW64, n=3, words 0xA…, 0xB…, 0xC…, `bc_ready_i`=1: exactly three outputs, equal to the words, on consecutive cycles. `done_o` fires the cycle after the third.
- EW16, n=6, words 0x4444_3333_2222_1111 and 0x8888_7777_6666_5555:
  - Outputs are 0x1111_1111_1111_1111, …, 0x6666_6666_6666_6666.
  - Exactly 2 operand handshakes.
  - 0x7777 and 0x8888 are never emitted.
- n=0: `done_o` pulses at T+1. `operand_ready_o` and `bc_valid_o` stay 0. `busy_o` stays 0.
- EW32, n=8, random `bc_ready_i`/`operand_valid_i`: no loss or duplication, and data is held stable while stalled. With both held high, there is no bubble at word boundaries.
- `flush_i` pulse after 2 of 5 elements, with a word held:
  - Next cycle: IDLE, `bc_valid_o`=0, no `done_o`.
  - A following EW64 n=1 command completes normally.
- `rst_ni` asserted mid-stream: all outputs return to reset values immediately. After release, a new command completes correctly.
